mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral on the data bus driven by the MEM stage, sitting beside the data memory in the `0x4000_0000` I/O window. Provides a reloadable up-counting timer with overflow interrupt and a free-running system tick counter. The MEM stage reads and writes it with the same Address/WriteData/MemRead/MemWrite signals it drives into data memory, and selects `ReadData` when `Hit` is high.

## Interface

Parameters:
- `BASE_ADDR`, `32'h40000000`: base of the 32-byte register window.
- `PRESCALE`, `1`: clock cycles per timer tick. Legal range is 1..65535.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `Address`, input, 32: byte address from the MEM stage.
- `WriteData`, input, 32: store data.
- `MemRead`, input, 1: load strobe.
- `MemWrite`, input, 1: store strobe.
- `ReadData`, output, 32: combinational read data.
- `Hit`, output, 1: `Address` falls within `BASE_ADDR..BASE_ADDR+0x1F`.
- `IRQ`, output, 1: timer interrupt request, level-sensitive.
- `SysTick`, output, 32: free-running cycle counter.

## Operation

- Register map, word offsets; `Address[1:0]` is ignored:
  - 0x00 `TH`: reload value, R/W.
  - 0x04 `TL`: counter, R/W.
  - 0x08 `TCON`: bit0 EN, bit1 IE, bit2 IF. IF is write-1-to-clear. Bits [31:3] read as 0.
  - 0x14 `SYSTICK`: read-only. Writes are ignored.
  - Other offsets in the window read as 0 and ignore writes.
- `Hit` = (`Address[31:5]` == `BASE_ADDR[31:5]`). It is independent of MemRead and MemWrite.
- `ReadData` = selected register when `Hit & MemRead`; otherwise 0.
- Write fires when `Hit & MemWrite` at the clock edge.
- Prescaler:
  - 16-bit counter `pcnt`.
  - While EN=1, it counts 0..PRESCALE-1 and a tick is asserted in the cycle `pcnt == PRESCALE-1`; `pcnt` then wraps to 0.
  - While EN=0, `pcnt` is held at 0.
  - Writing TCON with EN transitioning 0→1 restarts `pcnt` at 0.
- Timer behaviour on a tick:
  - If `TL == 32'hFFFFFFFF`: `TL <= TH`, and if IE=1 then `IF <= 1`.
  - Otherwise `TL <= TL + 1` (32-bit, unsigned).
- `IRQ` = IE & IF, registered bits ANDed combinationally.
- `SysTick` increments by 1 every cycle after reset and wraps from `32'hFFFFFFFF` to 0. It ignores EN.
- Simultaneous events:
  - A CPU write to `TL` in a tick cycle: the written value wins and that tick's increment/reload is discarded.
  - A CPU write to `TH` in an overflow cycle: the reload uses the old `TH`; the new `TH` takes effect from the next overflow.
  - A TCON write with bit2=1 (clear IF) in the same cycle an overflow sets IF: set wins, IF=1.
  - A TCON write with bit2=0 leaves IF unchanged. EN and IE take the written bits.
  - A TCON write clearing EN in a tick cycle: that tick still applies. The counter is frozen from the next cycle.
- Reset (`reset`=0 at an edge): TH=0, TL=0, TCON=0, `pcnt`=0, SysTick=0. It overrides any simultaneous write or tick, and may be asserted mid-count; all state returns to reset values.

## Timing

- Reset values seen from the cycle after the reset edge: `ReadData`=0, `Hit` follows `Address`, `IRQ`=0, `SysTick`=0.
- Write latency: 1 clock. A read in the cycle after a write returns the new value.
- Read latency: 0 clocks, combinational from `Address`, MemRead and the current registers. There is no read side effect.
- With PRESCALE=N and EN set at edge k, `TL` first increments at edge k+N.
- `IF` is set at the same edge that reloads `TL`. `IRQ` rises in the cycle after that edge.
- `SysTick` reads `n` in the n-th cycle after reset release; it reads 0 in the first cycle.
- No stall or handshake: every access completes in the cycle it is presented.

## Test plan

- Reset and SysTick:
  - Stimulus: hold `reset`=0 for 3 cycles, release, then read 0x08.
  - Required: 0; `IRQ`=0; `SysTick` equals cycles since release; after 10 cycles, reading 0x14 returns 10.
- Reload and interrupt, PRESCALE=1:
  - Stimulus: write TH=`FFFFFFFC`, TL=`FFFFFFFE`, TCON=3.
  - Required: TL sequence `FFFFFFFF`, `FFFFFFFC`, `FFFFFFFD`; `IRQ` rises in the cycle after the reload; writing TCON=7 keeps EN/IE and clears IF, and `IRQ` falls next cycle.
- Prescaler, PRESCALE=4:
  - Stimulus: TL=0, TCON=1, then run 12 cycles.
  - Required: TL=3. Clear EN; TL holds at 3 for 10 cycles. Re-enable; the next increment occurs exactly 4 cycles later.
- Simultaneous events:
  - Stimulus 1: W1C of IF in the same cycle as an overflow. Required: IF=1.
  - Stimulus 2: write TL=5 in a tick cycle. Required: TL=5, not incremented.
- Decode:
  - Stimulus: access `BASE_ADDR+0x0C`, `BASE_ADDR+0x20`, `BASE_ADDR+0x06`.
  - Required, in order: `Hit`=1 with `ReadData`=0 and no state change; `Hit`=0 with `ReadData`=0; `ReadData`=TL; a write to SYSTICK is ignored.
- Mid-count reset:
  - Stimulus: TL=`00000010`, EN=1; assert `reset`=0 for 1 cycle.
  - Required: TL=0, TCON=0, `SysTick`=0, `IRQ`=0.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped reloadable up-counting timer with overflow interrupt, plus a
// free-running cycle counter, decoded in a 32-byte window at BASE_ADDR.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        IRQ,
  output logic [31:0] SysTick
);

  localparam logic [2:0]  OFF_TH      = 3'd0;
  localparam logic [2:0]  OFF_TL      = 3'd1;
  localparam logic [2:0]  OFF_TCON    = 3'd2;
  localparam logic [2:0]  OFF_SYSTICK = 3'd5;
  localparam logic [15:0] PCNT_LAST   = 16'(PRESCALE - 1);

  logic [31:0] th;
  logic [31:0] tl;
  logic        tcon_en;
  logic        tcon_ie;
  logic        tcon_if;
  logic [15:0] pcnt;

  logic [2:0]  off;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        ovf;
  logic [31:0] tl_next;
  logic        if_next;
  logic [15:0] pcnt_next;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, Address[1:0]};

  assign Hit     = (Address[31:5] == BASE_ADDR[31:5]);
  assign off     = Address[4:2];
  assign wr_th   = Hit && MemWrite && (off == OFF_TH);
  assign wr_tl   = Hit && MemWrite && (off == OFF_TL);
  assign wr_tcon = Hit && MemWrite && (off == OFF_TCON);

  assign tick = tcon_en && (pcnt == PCNT_LAST);
  assign ovf  = tick && (tl == 32'hFFFF_FFFF);
  assign IRQ  = tcon_ie & tcon_if;

  always_comb begin
    tl_next   = tl;
    if_next   = tcon_if;
    pcnt_next = pcnt + 16'd1;

    // A CPU write to TL discards the tick; reload always uses the current TH.
    if (wr_tl) begin
      tl_next = WriteData;
    end else if (ovf) begin
      tl_next = th;
    end else if (tick) begin
      tl_next = tl + 32'd1;
    end

    // Overflow setting IF beats a simultaneous write-1-to-clear.
    if (ovf && tcon_ie) begin
      if_next = 1'b1;
    end else if (wr_tcon && WriteData[2]) begin
      if_next = 1'b0;
    end

    // Prescaler rests at 0 while disabled, so enabling always starts a fresh period.
    if (!tcon_en || tick || (wr_tcon && !WriteData[0])) begin
      pcnt_next = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th      <= 32'd0;
      tl      <= 32'd0;
      tcon_en <= 1'b0;
      tcon_ie <= 1'b0;
      tcon_if <= 1'b0;
      pcnt    <= 16'd0;
      SysTick <= 32'd0;
    end else begin
      tl      <= tl_next;
      tcon_if <= if_next;
      pcnt    <= pcnt_next;
      SysTick <= SysTick + 32'd1;
      if (wr_th) begin
        th <= WriteData;
      end
      if (wr_tcon) begin
        tcon_en <= WriteData[0];
        tcon_ie <= WriteData[1];
      end
    end
  end

  always_comb begin
    ReadData = 32'd0;
    if (Hit && MemRead) begin
      case (off)
        OFF_TH:      ReadData = th;
        OFF_TL:      ReadData = tl;
        OFF_TCON:    ReadData = {29'd0, tcon_if, tcon_ie, tcon_en};
        OFF_SYSTICK: ReadData = SysTick;
        default:     ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: two instances (PRESCALE 1 and 4) on one bus, checked
// every cycle against a behavioural register-level model plus directed scenarios.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mr;
  logic        mw;
  logic [31:0] rd1, rd4, st1, st4;
  logic        hit1, hit4, irq1, irq4;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .Address(addr), .WriteData(wdata),
    .MemRead(mr), .MemWrite(mw), .ReadData(rd1), .Hit(hit1),
    .IRQ(irq1), .SysTick(st1)
  );

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .Address(addr), .WriteData(wdata),
    .MemRead(mr), .MemWrite(mw), .ReadData(rd4), .Hit(hit4),
    .IRQ(irq4), .SysTick(st4)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4.
  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  logic        m_en [2];
  logic        m_ie [2];
  logic        m_if [2];
  int          m_ph [2];
  logic [31:0] m_st;
  bit          m_valid = 1'b0;

  logic [31:0] s_rd1, s_rd4, s_st1, s_mst;
  logic        s_irq1, s_hit1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic int word_off(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    if (!(in_window(addr) && mr)) return 32'd0;
    case (word_off(addr))
      0: return m_th[k];
      1: return m_tl[k];
      2: return {29'd0, m_if[k], m_ie[k], m_en[k]};
      5: return m_st;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_edge();
    int          n;
    bit          w, tk, ov;
    int          o;
    logic [31:0] tl_n;
    logic        if_n, en_n, ie_n;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_th[k] = 0; m_tl[k] = 0; m_en[k] = 0; m_ie[k] = 0; m_if[k] = 0; m_ph[k] = 0;
      end
      m_st    = 0;
      m_valid = 1'b1;
      return;
    end
    w = in_window(addr) && mw;
    o = word_off(addr);
    for (int k = 0; k < 2; k++) begin
      n    = (k == 0) ? 1 : 4;
      tk   = m_en[k] && (m_ph[k] == n - 1);
      ov   = tk && (m_tl[k] == 32'hFFFFFFFF);
      tl_n = m_tl[k];
      if (tk) tl_n = ov ? m_th[k] : m_tl[k] + 32'd1;
      if_n = m_if[k] | (ov & m_ie[k]);
      en_n = m_en[k];
      ie_n = m_ie[k];
      if (w) begin
        if (o == 0) m_th[k] = wdata;
        if (o == 1) tl_n = wdata;
        if (o == 2) begin
          en_n = wdata[0];
          ie_n = wdata[1];
          if (wdata[2] && !(ov && m_ie[k])) if_n = 1'b0;
        end
      end
      m_ph[k] = (m_en[k] && en_n) ? (m_ph[k] + 1) % n : 0;
      m_tl[k] = tl_n;
      m_if[k] = if_n;
      m_en[k] = en_n;
      m_ie[k] = ie_n;
    end
    m_st = m_st + 32'd1;
  endfunction

  task automatic check_outputs();
    if (!m_valid) return;
    chk("u1_hit", hit1, in_window(addr));
    chk("u4_hit", hit4, in_window(addr));
    chk("u1_rd", rd1, exp_rd(0));
    chk("u4_rd", rd4, exp_rd(1));
    chk("u1_irq", irq1, m_ie[0] & m_if[0]);
    chk("u4_irq", irq4, m_ie[1] & m_if[1]);
    chk("u1_systick", st1, m_st);
    chk("u4_systick", st4, m_st);
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic rq, input logic wq);
    reset = r; addr = a; wdata = d; mr = rq; mw = wq;
    @(negedge clk);
    check_outputs();
    s_rd1 = rd1; s_rd4 = rd4; s_st1 = st1; s_irq1 = irq1; s_hit1 = hit1; s_mst = m_st;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    step(1'b1, BASE + o, d, 1'b0, 1'b1);
  endtask

  task automatic rdr(input logic [31:0] o);
    step(1'b1, BASE + o, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          sel;
    reset = 1'b0; addr = 0; wdata = 0; mr = 0; mw = 0;

    // Reset and SysTick
    repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rdr(32'h08);
    chk("rst_tcon", s_rd1, 32'd0);
    chk("rst_irq", s_irq1, 1'b0);
    chk("rst_systick0", s_st1, 32'd0);
    repeat (9) idle();
    rdr(32'h14);
    chk("systick10", s_rd1, 32'd10);

    // Reload and interrupt at PRESCALE 1
    wr(32'h00, 32'hFFFFFFFC);
    wr(32'h04, 32'hFFFFFFFE);
    wr(32'h08, 32'd3);
    rdr(32'h04); chk("tl_seq0", s_rd1, 32'hFFFFFFFE);
    rdr(32'h04); chk("tl_seq1", s_rd1, 32'hFFFFFFFF); chk("irq_pre", s_irq1, 1'b0);
    rdr(32'h04); chk("tl_seq2", s_rd1, 32'hFFFFFFFC); chk("irq_rise", s_irq1, 1'b1);
    rdr(32'h04); chk("tl_seq3", s_rd1, 32'hFFFFFFFD);
    wr(32'h08, 32'd7); chk("irq_hold", s_irq1, 1'b1);
    rdr(32'h08); chk("w1c_tcon", s_rd1, 32'd3); chk("irq_fall", s_irq1, 1'b0);
    wr(32'h08, 32'd0);

    // Prescaler at PRESCALE 4
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd1);
    repeat (12) idle();
    rdr(32'h04); chk("ps4_tl3", s_rd4, 32'd3);
    wr(32'h08, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rdr(32'h04); chk("ps4_frozen", s_rd4, 32'd3);
    end
    wr(32'h08, 32'd1);
    for (int i = 0; i < 5; i++) begin
      rdr(32'h04); chk("ps4_restart", s_rd4, (i < 4) ? 32'd3 : 32'd4);
    end
    wr(32'h08, 32'd0);

    // Simultaneous events
    wr(32'h00, 32'd0);
    wr(32'h04, 32'hFFFFFFFE);
    wr(32'h08, 32'd3);
    idle();
    wr(32'h08, 32'd7);
    rdr(32'h08); chk("set_beats_clr", s_rd1, 32'd7); chk("set_irq", s_irq1, 1'b1);
    wr(32'h08, 32'd4);
    wr(32'h08, 32'd1);
    wr(32'h04, 32'd5);
    rdr(32'h04); chk("tl_write_wins", s_rd1, 32'd5);
    wr(32'h08, 32'd0);

    // Decode
    wr(32'h04, 32'h00001234);
    rdr(32'h0C); chk("dec_0c_hit", s_hit1, 1'b1); chk("dec_0c_rd", s_rd1, 32'd0);
    wr(32'h0C, 32'hFFFFFFFF);
    step(1'b1, BASE + 32'h20, 32'd0, 1'b1, 1'b0);
    chk("dec_20_hit", s_hit1, 1'b0); chk("dec_20_rd", s_rd1, 32'd0);
    step(1'b1, BASE + 32'h06, 32'd0, 1'b1, 1'b0);
    chk("dec_06_tl", s_rd1, 32'h00001234);
    wr(32'h14, 32'd0);
    rdr(32'h14); chk("systick_ro", s_rd1, s_mst);

    // Mid-count reset
    wr(32'h04, 32'h00000010);
    wr(32'h08, 32'd3);
    idle();
    step(1'b0, BASE + 32'h04, 32'h55, 1'b0, 1'b1);
    rdr(32'h04); chk("mrst_tl", s_rd1, 32'd0); chk("mrst_systick", s_st1, 32'd0);
    chk("mrst_irq", s_irq1, 1'b0);
    rdr(32'h08); chk("mrst_tcon", s_rd1, 32'd0);

    // Randomized traffic, biased toward overflow
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) a = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
      else if (sel == 8) a = BASE + 32'h20;
      else a = $urandom;
      d = $urandom;
      if (d[31]) d = 32'hFFFFFFF0 | ($urandom & 32'hF);
      step(($urandom_range(0, 99) != 0), a, d, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
